dec_sel_sequencer: RTL and testbench



---
 rtl/dec_sel_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dec_sel_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer: drives the select/enable of a 3-to-8 one-hot decoder.
// It walks the channels set in a latched 8-bit mask and holds each one for a
// programmable number of cycles. Single-pass or continuous scanning is chosen
// at start.
// Optional build macro DEC_SEL_GAP_EN adds a one-cycle break-before-make
// GAP state on every channel change.
module dec_sel_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done
);

`ifdef DEC_SEL_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_DWELL = 2'd2,
    ST_GAP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;
`endif

  // Returns {found, index} of the lowest set mask bit whose index is >= from.
  // from is 4 bits wide so that "current + 1" past channel 7 finds nothing.
  function automatic logic [3:0] lowest_from(input logic [7:0] mask,
                                             input logic [3:0] from);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  state_t             state_r, state_n;
  logic [2:0]         sel_r, sel_n;
  logic               sel_en_r, sel_en_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;
  logic [7:0]         mask_r, mask_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n;
  logic               cont_r, cont_n;
  logic [2:0]         ptr_r, ptr_n;
  logic [DWELL_W-1:0] cnt_r, cnt_n;

  logic [3:0]         first_s;
  logic [3:0]         next_s;
  logic [3:0]         wrap_s;
  logic [2:0]         tgt_s;

  // Channel search: first pick after SEEK, successor of current, wrap target.
  always_comb begin
    first_s = lowest_from(mask_r, {1'b0, ptr_r});
    next_s  = lowest_from(mask_r, {1'b0, sel_r} + 4'd1);
    wrap_s  = lowest_from(mask_r, 4'd0);
    if (next_s[3]) begin
      tgt_s = next_s[2:0];
    end else begin
      tgt_s = wrap_s[2:0];
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n  = state_r;
    sel_n    = sel_r;
    sel_en_n = sel_en_r;
    busy_n   = busy_r;
    done_n   = 1'b0;
    mask_n   = mask_r;
    dwell_n  = dwell_r;
    cont_n   = cont_r;
    ptr_n    = ptr_r;
    cnt_n    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        sel_en_n = 1'b0;
        busy_n   = 1'b0;
        if (start && !stop) begin
          if (ch_mask != 8'd0) begin
            mask_n  = ch_mask;
            dwell_n = (dwell == '0) ? DWELL_W'(1) : dwell;
            cont_n  = cont;
            ptr_n   = 3'd0;
            busy_n  = 1'b1;
            state_n = ST_SEEK;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SEEK: begin
        if (stop) begin
          state_n  = ST_IDLE;
          sel_en_n = 1'b0;
          busy_n   = 1'b0;
        end else begin
          state_n  = ST_DWELL;
          sel_n    = first_s[2:0];
          sel_en_n = 1'b1;
          cnt_n    = dwell_r;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          state_n  = ST_IDLE;
          sel_en_n = 1'b0;
          busy_n   = 1'b0;
        end else if (cnt_r <= DWELL_W'(1)) begin
          if (next_s[3] || cont_r) begin
`ifdef DEC_SEL_GAP_EN
            state_n  = ST_GAP;
            sel_en_n = 1'b0;
            ptr_n    = tgt_s;
`else
            sel_n    = tgt_s;
            sel_en_n = 1'b1;
            cnt_n    = dwell_r;
`endif
          end else begin
            state_n  = ST_IDLE;
            sel_en_n = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt_r - DWELL_W'(1);
        end
      end
`ifdef DEC_SEL_GAP_EN
      ST_GAP: begin
        if (stop) begin
          state_n  = ST_IDLE;
          sel_en_n = 1'b0;
          busy_n   = 1'b0;
        end else begin
          state_n  = ST_DWELL;
          sel_n    = ptr_r;
          sel_en_n = 1'b1;
          cnt_n    = dwell_r;
        end
      end
`endif
      default: begin
        state_n  = ST_IDLE;
        sel_en_n = 1'b0;
        busy_n   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      sel_r    <= 3'd0;
      sel_en_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      mask_r   <= 8'd0;
      dwell_r  <= '0;
      cont_r   <= 1'b0;
      ptr_r    <= 3'd0;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_n;
      sel_r    <= sel_n;
      sel_en_r <= sel_en_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
      mask_r   <= mask_n;
      dwell_r  <= dwell_n;
      cont_r   <= cont_n;
      ptr_r    <= ptr_n;
      cnt_r    <= cnt_n;
    end
  end

  assign sel    = sel_r;
  assign sel_en = sel_en_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Testbench for dec_sel_sequencer. Expected output traces are built from the
// scan rules (list of set channels, dwell repeats, optional gaps) and compared
// cycle by cycle. Define DEC_SEL_GAP_EN for both bench and RTL to check GAP.
module tb_dec_sel_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_en;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_err;
  logic [2:0] model_sel;
  bit gap_en;

  dec_sel_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .ch_mask(ch_mask), .dwell(dwell), .sel(sel), .sel_en(sel_en),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {sel, sel_en, busy, done};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed sel/en/busy/done=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Build the expected trace for one scan, starting with the SEEK cycle.
  task automatic build(input logic [7:0] m, input logic [7:0] d, input bit c,
                       input int nch, output logic [5:0] q[$]);
    int chans[$];
    int de;
    int total;
    logic [2:0] prev;
    logic [2:0] ch;
    q = {};
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    de = (d == 8'd0) ? 1 : int'(d);
    q.push_back({model_sel, 3'b010});
    prev = model_sel;
    total = c ? nch : chans.size();
    for (int k = 0; k < total; k++) begin
      ch = 3'(chans[k % chans.size()]);
      if (gap_en && k > 0) q.push_back({prev, 3'b010});
      for (int r = 0; r < de; r++) q.push_back({ch, 3'b110});
      prev = ch;
    end
    if (!c) q.push_back({prev, 3'b001});
  endtask

  // Run one scan; stop_at < 0 means no early stop. noise perturbs inputs.
  task automatic run_scan(input string tag, input logic [7:0] m,
                          input logic [7:0] d, input bit c, input int nch,
                          input int stop_at, input bit noise);
    logic [5:0] q[$];
    bit stopped;
    build(m, d, c, nch, q);
    stopped = 1'b0;
    ch_mask = m; dwell = d; cont = c; start = 1'b1; stop = 1'b0;
    for (int j = 0; j < q.size(); j++) begin
      step();
      check(tag, q[j]);
      model_sel = q[j][5:3];
      start = 1'b0;
      if (noise) begin
        ch_mask = 8'($urandom);
        dwell   = 8'($urandom);
        cont    = 1'($urandom);
        start   = (!c && j == q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (j == stop_at) begin
        stop = 1'b1;
        step();
        check({tag, "_stop"}, {model_sel, 3'b000});
        stop = 1'b0; start = 1'b0;
        stopped = 1'b1;
        break;
      end
    end
    if (c && !stopped) begin
      stop = 1'b1;
      step();
      check({tag, "_cstop"}, {model_sel, 3'b000});
      stop = 1'b0;
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check({tag, "_idle"}, {model_sel, 3'b000});
    end
  endtask

  initial begin
    logic [7:0] m;
    int nch;
    int sa;
    bit c;
    n_cmp = 0; n_err = 0; model_sel = 3'd0;
`ifdef DEC_SEL_GAP_EN
    gap_en = 1'b1;
`else
    gap_en = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
    ch_mask = 8'd0; dwell = 8'd0;
    #23 rst_n = 1'b1;

    // Reset state held with no start.
    for (int i = 0; i < 10; i++) begin
      step();
      check("reset_idle", 6'b000_000);
    end

    // Directed single pass.
    run_scan("pass_a5", 8'b1010_0101, 8'd3, 1'b0, 0, -1, 1'b0);
    // Continuous two-channel wrap, stopped after six channel slots.
    run_scan("cont_81", 8'b1000_0001, 8'd2, 1'b1, 6, -1, 1'b0);
    // Single channel continuous.
    run_scan("cont_one", 8'b0000_1000, 8'd2, 1'b1, 3, -1, 1'b0);
    // Empty mask: done pulse only.
    ch_mask = 8'd0; dwell = 8'd3; start = 1'b1;
    step();
    check("mask0_done", {model_sel, 3'b001});
    start = 1'b0;
    step();
    check("mask0_after", {model_sel, 3'b000});
    // Dwell of zero behaves as one.
    run_scan("dwell0", 8'h10, 8'd0, 1'b0, 0, -1, 1'b0);
    // Start together with stop: no scan.
    ch_mask = 8'hff; dwell = 8'd2; start = 1'b1; stop = 1'b1;
    step();
    check("start_stop", {model_sel, 3'b000});
    start = 1'b0; stop = 1'b0;
    step();
    check("start_stop2", {model_sel, 3'b000});
    // Start while busy and mid-scan input changes are ignored.
    run_scan("noise", 8'b0110_0010, 8'd2, 1'b0, 0, -1, 1'b1);
    // Two adjacent channels (gap pattern when compiled in).
    run_scan("pair", 8'b0000_0011, 8'd2, 1'b0, 0, -1, 1'b0);
    // Stop during the SEEK cycle.
    run_scan("stop_seek", 8'h42, 8'd2, 1'b0, 0, 0, 1'b0);

    // Randomised scans.
    for (int t = 0; t < 30; t++) begin
      m = 8'($urandom);
      if (m == 8'd0) m = 8'h80;
      c = 1'($urandom);
      nch = $urandom_range(1, 10);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      run_scan("rand", m, 8'($urandom_range(0, 4)), c, nch, sa,
               1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a dwell.
    ch_mask = 8'hff; dwell = 8'd5; cont = 1'b0; start = 1'b1;
    step();
    check("rst_seek", {model_sel, 3'b010});
    start = 1'b0;
    step();
    check("rst_dw1", 6'b000_110);
    step();
    check("rst_dw2", 6'b000_110);
    step();
    check("rst_dw3", 6'b000_110);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 6'b000_000);
    model_sel = 3'd0;
    #10 rst_n = 1'b1;
    step();
    check("post_rst", 6'b000_000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
